// File: rtl/cust_queue_pkg.sv
// Package: cust_queue_pkg
// Purpose : default parameter constants and a width helper shared by the
//           customer queue counter and its sub-modules.
package cust_queue_pkg;

    localparam int CQ_DEPTH_DEF    = 7;
    localparam int CQ_PW_DEF       = 8;
    localparam int CQ_TELLERS_DEF  = 1;
    localparam int CQ_SVC_TIME_DEF = 4;

    // Bits needed to hold the values 0..n inclusive.
    function automatic int cq_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/cust_queue_counter_pulse_sync.sv
// Module : pulse_sync
// Purpose: two-flop synchroniser for an asynchronous level, followed by a
//          rising-edge detector that yields one clk-wide pulse per rise.
//          The level present when reset is released is taken as the
//          baseline, so an input already high at release never pulses.
// Ports  : clk_i   - clock
//          rst_ni  - asynchronous active-low reset
//          d_i     - asynchronous input level
//          pulse_o - one-cycle pulse per synchronised rising edge
module pulse_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic pulse_o
);

    logic       meta_q;
    logic       sync_q;
    logic       prev_q;
    logic [1:0] settle_q;
    logic       armed_s;

    // Synchroniser chain, edge-detect history and post-reset settle counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q   <= 1'b0;
            sync_q   <= 1'b0;
            prev_q   <= 1'b0;
            settle_q <= 2'd0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
            if (settle_q != 2'd3) begin
                settle_q <= settle_q + 2'd1;
            end else begin
                settle_q <= settle_q;
            end
        end
    end

    // The detector is only armed once the chain holds a genuinely sampled
    // level; until then a high input counts as the baseline, not a rise.
    assign armed_s = (settle_q == 2'd3);
    assign pulse_o = sync_q & ~prev_q & armed_s;

endmodule

// File: rtl/cust_queue_counter.sv
// Module : cust_queue_counter
// Purpose: counts customers in a queue from back (arrival) and front
//          (departure) photocells, tracks accepted arrivals per period and
//          keeps sticky overflow/underflow flags.
// Config : define CUST_WAIT_EST_EN to add the registered wait_est output
//          (ceil(count/TELLERS)*SVC_TIME, saturating at 16'hFFFF).
// Ports  : clk, rst (async active-low), bph/fph (async photocell levels),
//          period_clr, err_clr (sync pulses), count, period_cnt, full,
//          empty, ovf_err, udf_err, [wait_est].
module cust_queue_counter
    import cust_queue_pkg::*;
#(
    parameter int DEPTH    = CQ_DEPTH_DEF,
    parameter int PW       = CQ_PW_DEF,
    parameter int TELLERS  = CQ_TELLERS_DEF,
    parameter int SVC_TIME = CQ_SVC_TIME_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         bph,
    input  logic                         fph,
    input  logic                         period_clr,
    input  logic                         err_clr,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic [PW-1:0]                period_cnt,
    output logic                         full,
    output logic                         empty,
    output logic                         ovf_err,
    output logic                         udf_err
`ifdef CUST_WAIT_EST_EN
    ,
    output logic [15:0]                  wait_est
`endif
);

    localparam int            CW      = cq_width(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [PW-1:0] PMAX_C  = {PW{1'b1}};

    if (DEPTH < 1 || TELLERS < 1 || TELLERS > 8 || SVC_TIME < 0) begin : g_bad_params
        $error("cust_queue_counter: parameter out of range");
    end

    logic          arr_s;
    logic          dep_s;
    logic          accept_s;
    logic [CW-1:0] count_q,  count_d;
    logic [PW-1:0] period_q, period_d;
    logic          ovf_q,    ovf_d;
    logic          udf_q,    udf_d;
    logic          ovf_new_s;
    logic          udf_new_s;

    pulse_sync u_arr_sync (
        .clk_i   (clk),
        .rst_ni  (rst),
        .d_i     (bph),
        .pulse_o (arr_s)
    );

    pulse_sync u_dep_sync (
        .clk_i   (clk),
        .rst_ni  (rst),
        .d_i     (fph),
        .pulse_o (dep_s)
    );

    // Occupancy, period count and error flag next-state.
    always_comb begin
        count_d   = count_q;
        ovf_new_s = 1'b0;
        udf_new_s = 1'b0;
        case ({arr_s, dep_s})
            2'b10: begin
                if (count_q != DEPTH_C) begin
                    count_d = count_q + CW'(1);
                end else begin
                    ovf_new_s = 1'b1;
                end
            end
            2'b01: begin
                if (count_q != CW'(0)) begin
                    count_d = count_q - CW'(1);
                end else begin
                    udf_new_s = 1'b1;
                end
            end
            default: begin
                // idle, or a swap of one customer in and one out
                count_d = count_q;
            end
        endcase

        // A simultaneous departure frees the slot, so a full queue still
        // accepts a coincident arrival.
        accept_s = arr_s & (dep_s | (count_q != DEPTH_C));

        if (period_clr) begin
            period_d = accept_s ? PW'(1) : PW'(0);
        end else if (accept_s && (period_q != PMAX_C)) begin
            period_d = period_q + PW'(1);
        end else begin
            period_d = period_q;
        end

        ovf_d = (ovf_q & ~err_clr) | ovf_new_s;
        udf_d = (udf_q & ~err_clr) | udf_new_s;
    end

    // State registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q  <= '0;
            period_q <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            count_q  <= count_d;
            period_q <= period_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    assign count      = count_q;
    assign period_cnt = period_q;
    assign ovf_err    = ovf_q;
    assign udf_err    = udf_q;
    assign full       = (count_q == DEPTH_C);
    assign empty      = (count_q == CW'(0));

`ifdef CUST_WAIT_EST_EN
    logic [15:0] wait_q, wait_d;
    logic [31:0] groups_s;
    logic [31:0] prod_s;

    // Wait estimate from the registered occupancy, saturating to 16 bits.
    always_comb begin
        groups_s = (32'(count_q) + 32'(TELLERS) - 32'd1) / 32'(TELLERS);
        prod_s   = groups_s * 32'(SVC_TIME);
        if (prod_s > 32'h0000_FFFF) begin
            wait_d = 16'hFFFF;
        end else begin
            wait_d = prod_s[15:0];
        end
    end

    // Wait estimate register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_q <= 16'h0000;
        end else begin
            wait_q <= wait_d;
        end
    end

    assign wait_est = wait_q;
`endif

endmodule

// File: doc/cust_queue_counter.md
CUST_QUEUE_COUNTER -- requirements
Module: cust_queue_counter

Interface
REQ-001 Parameter DEPTH, default 7, maximum customers held in the queue (>=1).
REQ-002 Parameter PW, default 8, width of the per-period arrival count.
REQ-003 Parameter TELLERS, default 1, number of serving tellers (1..8).
REQ-004 Parameter SVC_TIME, default 4, service time per customer in time units.
REQ-005 Localparam CW = $clog2(DEPTH+1), the occupancy width.
REQ-006 Port clk, input, 1 bit; the single clock, all state on the rising edge.
REQ-007 Port rst, input, 1 bit; asynchronous, active-low reset.
REQ-008 Port bph, input, 1 bit; back photocell level (arrival), asynchronous.
REQ-009 Port fph, input, 1 bit; front photocell level (departure), asynchronous.
REQ-010 Port period_clr, input, 1 bit; synchronous one-cycle pulse that clears period_cnt.
REQ-011 Port err_clr, input, 1 bit; synchronous pulse that clears the sticky error flags.
REQ-012 Port count, output, CW bits; current queue occupancy.
REQ-013 Port period_cnt, output, PW bits; number of accepted arrivals since the last period_clr.
REQ-014 Port full and empty, outputs, 1 bit each; full = (count==DEPTH), empty = (count==0).
REQ-015 Port ovf_err and udf_err, outputs, 1 bit each; sticky overflow and underflow flags.
REQ-016 Port wait_est, output, 16 bits; present only when CUST_WAIT_EST_EN is defined.

Function
REQ-017 bph and fph SHALL each pass through a two-flop synchroniser followed by a rising-edge detector, so each input rise produces exactly one internal pulse (arr or dep).
REQ-018 On an input rising edge before clk edge k, count SHALL reflect the change after edge k+2 (3-edge latency); an input held high SHALL NOT produce further pulses.
REQ-019 arr alone with count<DEPTH: count+1 and period_cnt+1.
REQ-020 arr alone with count==DEPTH: count holds, ovf_err set, period_cnt unchanged (customer rejected).
REQ-021 dep alone with count>0: count-1.
REQ-022 dep alone with count==0: count holds at 0, udf_err set.
REQ-023 arr and dep in the same cycle: count unchanged, period_cnt+1, no error flag set, at any occupancy including 0 and DEPTH.
REQ-024 period_cnt SHALL saturate at 2^PW-1, with no wrap.
REQ-025 period_clr with a coincident accepted arrival: period_cnt = 1; otherwise period_cnt = 0.
REQ-026 err_clr clears both flags, but a new error in the same cycle leaves its flag set.
REQ-027 full and empty SHALL be decoded from the count register only, with no input-to-output combinational path.

Reset
REQ-028 While rst is low: count=0, period_cnt=0, ovf_err=0, udf_err=0, wait_est=0, empty=1, full=0, all synchroniser and edge flops cleared.
REQ-029 Reset asserted mid-operation SHALL discard any pending pulse; the first edge after release produces no pulse even if bph or fph is high.

Configuration
REQ-030 Macro CUST_WAIT_EST_EN defined: wait_est SHALL be a register equal to ceil(count/TELLERS)*SVC_TIME, updated one cycle after count changes and saturating at 16'hFFFF.
REQ-031 Macro CUST_WAIT_EST_EN undefined: the wait_est port and its logic SHALL be absent, with all other behaviour identical.

Structure
REQ-032 Package cust_queue_pkg SHALL hold the default parameter constants and a width helper function; the module imports it.
REQ-033 Sub-module pulse_sync (two-flop synchroniser plus rise detector, async active-low reset) SHALL be instantiated twice, once each for bph and fph.

Verification
REQ-034 Reset, then bph pulsed 3 times, then 3 idle cycles -> count=3, period_cnt=3, empty=0, full=0.
REQ-035 DEPTH=7, 8 bph pulses -> count=7, full=1, ovf_err=1, period_cnt=7; then err_clr -> ovf_err=0.
REQ-036 From empty, one fph pulse -> count=0, udf_err=1; bph and fph rising together at count=7 -> count=7, period_cnt+1, no flag set.
REQ-037 PW=3, 10 accepted arrivals interleaved with departures -> period_cnt=7 (saturated); period_clr coincident with an arrival -> period_cnt=1.
REQ-038 bph held high for 20 cycles -> exactly one increment; rst pulled low mid-sync then released with bph high -> count=0, no increment.
REQ-039 CUST_WAIT_EST_EN defined with TELLERS=2, SVC_TIME=4, count=5 -> wait_est=12 one cycle after count settles.
